// File: rtl/mix_w_transpose_if.sv
// Bundle of W-RAM read port, WT-RAM write port and run/valid handshake
// for the blocked weight transposer.
interface mix_w_transpose_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  run;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [107:0]          rdata;
  logic                  load;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [107:0]          wdata;

  // master: the transposer; slave: the controller / RAM side
  modport master (
    input  run, rdata,
    output valid, raddr, load, waddr, wdata
  );
  modport slave (
    output run, rdata,
    input  valid, raddr, load, waddr, wdata
  );
endinterface

// File: rtl/mix_w_transpose.sv
// Rebuilds the transposed weight RAM from the weight RAM, one 6x6 tile at a time:
// 7 read cycles fill the tile buffer, 6 write cycles emit its columns as WT rows.
module mix_w_transpose #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  mix_w_transpose_if.master  bus
);
  localparam int HID_DIM   = 24;
  localparam int DATA_N    = 6;
  localparam int N_LEN_W   = 18;
  localparam int WORD_W    = DATA_N * N_LEN_W;
  localparam int BLKS      = HID_DIM / DATA_N;
  localparam int MAT_WORDS = HID_DIM * BLKS;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         m_q, m_d, i_q, i_d, j_q, j_d;
  logic [2:0]         t_q, t_d;
  logic               valid_q, valid_d;
  logic [N_LEN_W-1:0] tile_q [DATA_N][DATA_N];
  logic [N_LEN_W-1:0] tile_d [DATA_N][DATA_N];
  logic [4:0]         rd_row, wr_row;
  logic [WORD_W-1:0]  wr_word;
  logic               last_tile;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [1:0] m,
                                                      input logic [4:0] row,
                                                      input logic [1:0] blk);
    return ADDR_WIDTH'(m) * ADDR_WIDTH'(MAT_WORDS)
         + ADDR_WIDTH'(row) * ADDR_WIDTH'(BLKS)
         + ADDR_WIDTH'(blk);
  endfunction

  assign rd_row    = {3'b000, i_q} * 5'd6 + {2'b00, t_q};
  assign wr_row    = {3'b000, j_q} * 5'd6 + {2'b00, t_q};
  assign last_tile = (m_q == 2'd2) && (i_q == 2'd3) && (j_q == 2'd3);

  // WT word element gi is tile row gi, column u (u reuses the t counter)
  for (genvar gi = 0; gi < DATA_N; gi++) begin : g_wr_word
    assign wr_word[WORD_W-1-N_LEN_W*gi -: N_LEN_W] = tile_q[gi][t_q];
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    i_d     = i_q;
    j_d     = j_q;
    t_d     = t_q;
    tile_d  = tile_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = READ;
          m_d = '0; i_d = '0; j_d = '0; t_d = '0;
        end
      end
      READ: begin
        // rdata lags raddr by one cycle, so cycle t returns row t-1
        if (t_q != 3'd0) begin
          for (int e = 0; e < DATA_N; e++) begin
            tile_d[t_q - 3'd1][e] = bus.rdata[WORD_W-1-N_LEN_W*e -: N_LEN_W];
          end
        end
        if (t_q == 3'd6) begin
          state_d = WRITE;
          t_d     = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      WRITE: begin
        if (t_q == 3'd5) begin
          t_d = '0;
          if (last_tile) begin
            state_d = DONE;
            m_d = '0; i_d = '0; j_d = '0;
          end else begin
            state_d = READ;
            j_d     = j_q + 2'd1;
            if (j_q == 2'd3) begin
              i_d = i_q + 2'd1;
              if (i_q == 2'd3) m_d = m_q + 2'd1;
            end
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DONE: begin
        if (!bus.run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Dropping run mid-pass abandons the pass; the next run starts over
    if ((state_q == READ || state_q == WRITE) && !bus.run) begin
      state_d = IDLE;
      m_d = '0; i_d = '0; j_d = '0; t_d = '0;
    end
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      t_q     <= '0;
      valid_q <= 1'b0;
      for (int r = 0; r < DATA_N; r++) begin
        for (int e = 0; e < DATA_N; e++) begin
          tile_q[r][e] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      i_q     <= i_d;
      j_q     <= j_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      tile_q  <= tile_d;
    end
  end

  always_comb begin
    bus.raddr = '0;
    bus.load  = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    if (state_q == READ && t_q != 3'd6) begin
      bus.raddr = word_addr(m_q, rd_row, j_q);
    end
    if (state_q == WRITE) begin
      bus.load  = 1'b1;
      bus.waddr = word_addr(m_q, wr_row, i_q);
      bus.wdata = wr_word;
    end
  end

  assign bus.valid = valid_q;

endmodule
